rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-back arbiter for the 16-entry × 16-bit register file. It shares the file's single write port (rd / writedata / write enable) between two requesters: the memory-load path and the ALU result path. It sits between the execute/memory stages and the register file. It registers the winning write, so the write reaches the file one cycle after the grant. It also provides optional read-port forwarding of that in-flight write.

## Interface
- DATA_W, 16, register data width
- ADDR_W, 4, register address width (16 registers)
- STARVE_LIMIT, 3, consecutive ALU denials before ALU is forced to win (≥1)

- CLK  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- mem_valid  in  1  memory-load write request
- mem_rd  in  ADDR_W  memory-load destination register
- mem_data  in  DATA_W  memory-load write data
- mem_ready  out  1  grant to memory requester
- alu_valid  in  1  ALU write request
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU write data
- alu_ready  out  1  grant to ALU requester
- rf_we  out  1  register-file write enable (registered)
- rf_rd  out  ADDR_W  register-file write address (registered)
- rf_writedata  out  DATA_W  register-file write data (registered)
- rs1, rs2  in  ADDR_W  register-file read addresses, used for forwarding
- fwd1_hit, fwd2_hit  out  1  in-flight write matches rs1 / rs2
- fwd1_data, fwd2_data  out  DATA_W  forwarded data for rs1 / rs2

## Operation
- Handshake: valid/ready per requester. A transfer occurs on a cycle with valid && ready. The requester holds valid, rd and data stable until that cycle. ready is combinational from valid and arbiter state, and never depends on it own requester's data.
- Arbitration state is two-state FSM NORMAL / AGED, driven by a starve counter (width clog2(STARVE_LIMIT+1)).
- NORMAL: memory has priority. The ALU is granted only when mem_valid=0.
- Starve counter increments on cycles where alu_valid && !alu_ready, saturating at STARVE_LIMIT. It clears on an ALU transfer or when alu_valid=0.
- Counter == STARVE_LIMIT → AGED. In AGED, the ALU wins even if mem_valid=1. After the ALU transfer, the counter clears and the FSM returns to NORMAL.
- Only one ready is high per cycle. With no valid request, both readies are 0.
- The granted request is registered: the next cycle shows rf_we=1, rf_rd=rd, rf_writedata=data.
- Register 0 is hardwired zero. A transfer with rd=0 completes the handshake but produces rf_we=0 next cycle.
- With no transfer, rf_we=0 next cycle. rf_rd and rf_writedata hold their previous values.

## Timing
- Grant to write: 1 cycle latency. Throughput: one write per cycle.
- During reset (reset=0 at an edge):
  - rf_we=0, rf_rd=0, rf_writedata=0, starve counter=0, FSM=NORMAL.
  - mem_ready=alu_ready=0 for the whole time reset is low.
- Reset mid-operation: a transfer coinciding with reset low is dropped and no write issues. Requesters re-present after release.
- Simultaneous valid with counter below STARVE_LIMIT: memory wins and the counter increments.
- Forwarding is combinational from the registered outputs: fwdN_hit = rf_we && (rf_rd == rsN) && (rsN != 0), and fwdN_data = rf_writedata.

## Configuration
- RF_WB_BYPASS_EN defined: the forwarding logic above is built.
- Not defined: fwd1_hit=fwd2_hit=0 and fwd1_data=fwd2_data=0 constantly. The ports remain so the interface is unchanged.

## Structure
- Shared package rf_pkg: DATA_W/ADDR_W constants, register-index type, the arbiter FSM state enum (NORMAL, AGED), and the zero-register constant.
- One sub-module, rf_wb_fwd: the forwarding comparator, instantiated twice (rs1, rs2) under RF_WB_BYPASS_EN.

## Test plan
- Reset: hold reset=0 for 5 cycles with both valids high → both readies 0 and rf_we=0. Release → first write appears the cycle after first grant.
- Memory only: mem_valid=1, mem_rd=5, mem_data=16'hBEEF → mem_ready=1. The next cycle shows rf_we=1, rf_rd=5, rf_writedata=16'hBEEF.
- Contention/aging with STARVE_LIMIT=3: both valid continuously (mem rd=1..n, alu rd=7 data=16'h1234) → memory granted 3 cycles. The ALU is granted on the 4th, its write appears on the 5th, then memory resumes priority.
- Zero register: alu_valid=1, alu_rd=0, alu_data=16'hFFFF → alu_ready=1, next cycle rf_we=0, and the handshake completes with no retry.
- Forwarding (RF_WB_BYPASS_EN): an ALU write to r3 with 16'h00A5 while rs1=3, rs2=0 in the write cycle → fwd1_hit=1, fwd1_data=16'h00A5, fwd2_hit=0. Without the macro, all fwd outputs are 0.
- Reset mid-transfer: reset=0 on the same edge as a mem transfer to r9 → no rf_we the following cycle, starve counter 0.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file widths, index type, arbiter state enum and zero-register constant
package rf_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;
  typedef enum logic {NORMAL, AGED} arb_state_e;
  localparam reg_idx_t ZERO_REG = '0;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: requester handshakes, register-file write port and forwarding signals
interface rf_wb_arbiter_if;
  import rf_pkg::*;
  logic      mem_valid;
  reg_idx_t  mem_rd;
  reg_data_t mem_data;
  logic      mem_ready;
  logic      alu_valid;
  reg_idx_t  alu_rd;
  reg_data_t alu_data;
  logic      alu_ready;
  logic      rf_we;
  reg_idx_t  rf_rd;
  reg_data_t rf_writedata;
  reg_idx_t  rs1;
  reg_idx_t  rs2;
  logic      fwd1_hit;
  logic      fwd2_hit;
  reg_data_t fwd1_data;
  reg_data_t fwd2_data;
  modport master (
    output mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data, rs1, rs2,
    input  mem_ready, alu_ready, rf_we, rf_rd, rf_writedata,
           fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
  );
  modport slave (
    input  mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data, rs1, rs2,
    output mem_ready, alu_ready, rf_we, rf_rd, rf_writedata,
           fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
  );
endinterface

// File: rtl/rf_wb_fwd.sv
// rf_wb_fwd: compares one read address against the in-flight register-file write
module rf_wb_fwd
  import rf_pkg::*;
(
  input  logic      we,
  input  reg_idx_t  rd,
  input  reg_data_t data,
  input  reg_idx_t  rs,
  output logic      hit,
  output reg_data_t fdata
);
  assign hit   = we && (rd == rs) && (rs != ZERO_REG);
  assign fdata = data;
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between load and ALU paths with ALU aging; RF_WB_BYPASS_EN builds read forwarding
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input logic CLK,
  input logic reset,
  rf_wb_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  arb_state_e state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic mem_go, alu_go, go;
  reg_idx_t w_rd;
  reg_data_t w_data;
  // grant selection, starve counting and next arbitration state
  always_comb begin
    mem_go   = reset && bus.mem_valid && !(state == AGED && bus.alu_valid);
    alu_go   = reset && bus.alu_valid && !mem_go;
    go       = mem_go || alu_go;
    w_rd     = mem_go ? bus.mem_rd : bus.alu_rd;
    w_data   = mem_go ? bus.mem_data : bus.alu_data;
    cnt_nx   = (!bus.alu_valid || alu_go) ? '0 : (cnt == LIM) ? cnt : cnt + 1'b1;
    state_nx = (cnt_nx == LIM) ? AGED : NORMAL;
  end
  assign bus.mem_ready = mem_go;
  assign bus.alu_ready = alu_go;
  // arbitration state register
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state <= NORMAL;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end
  // registered write port; writes to the zero register are swallowed
  always_ff @(posedge CLK) begin
    if (!reset) begin
      bus.rf_we        <= 1'b0;
      bus.rf_rd        <= '0;
      bus.rf_writedata <= '0;
    end else begin
      bus.rf_we <= go && (w_rd != ZERO_REG);
      if (go && (w_rd != ZERO_REG)) begin
        bus.rf_rd        <= w_rd;
        bus.rf_writedata <= w_data;
      end
    end
  end
`ifdef RF_WB_BYPASS_EN
  rf_wb_fwd u_fwd1 (
    .we(bus.rf_we), .rd(bus.rf_rd), .data(bus.rf_writedata), .rs(bus.rs1),
    .hit(bus.fwd1_hit), .fdata(bus.fwd1_data)
  );
  rf_wb_fwd u_fwd2 (
    .we(bus.rf_we), .rd(bus.rf_rd), .data(bus.rf_writedata), .rs(bus.rs2),
    .hit(bus.fwd2_hit), .fdata(bus.fwd2_data)
  );
`else
  assign bus.fwd1_hit  = 1'b0;
  assign bus.fwd2_hit  = 1'b0;
  assign bus.fwd1_data = '0;
  assign bus.fwd2_data = '0;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed stimulus with a per-cycle reference model and literal spot checks
module tb_rf_wb_arbiter;
  localparam int LIMIT = 3;
  logic CLK = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int passed = 0;
  int denials = 0;
  bit started = 0;
  bit known = 1;
  logic e_we = 1'b0;
  logic [3:0] e_rd = '0;
  logic [15:0] e_data = '0;
  rf_wb_arbiter_if bus ();
  rf_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.CLK(CLK), .reset(reset), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask
  function automatic logic exp_mr();
    return reset && bus.mem_valid && !(denials >= LIMIT && bus.alu_valid);
  endfunction
  function automatic logic exp_ar();
    return reset && bus.alu_valid && !exp_mr();
  endfunction
  always @(posedge CLK) begin
    logic mr, ar;
    logic [3:0] wr;
    mr = exp_mr();
    ar = exp_ar();
    started = 1;
    if (!reset) begin
      denials = 0;
      e_we = 0;
      e_rd = 0;
      e_data = 0;
      known = 1;
    end else begin
      denials = (bus.alu_valid && !ar) ? ((denials + 1 > LIMIT) ? LIMIT : denials + 1) : 0;
      wr = mr ? bus.mem_rd : bus.alu_rd;
      if ((mr || ar) && wr == 0) begin
        e_we = 0;
        known = 0;
      end else if (mr || ar) begin
        e_we = 1;
        e_rd = wr;
        e_data = mr ? bus.mem_data : bus.alu_data;
        known = 1;
      end else e_we = 0;
    end
  end
  always @(negedge CLK) begin
    if (started) begin
      chk("m_mem_ready", 32'(bus.mem_ready), 32'(exp_mr()));
      chk("m_alu_ready", 32'(bus.alu_ready), 32'(exp_ar()));
      chk("m_rf_we", 32'(bus.rf_we), 32'(e_we));
      if (known) begin
        chk("m_rf_rd", 32'(bus.rf_rd), 32'(e_rd));
        chk("m_rf_writedata", 32'(bus.rf_writedata), 32'(e_data));
      end
`ifdef RF_WB_BYPASS_EN
      chk("m_fwd1_hit", 32'(bus.fwd1_hit), 32'(e_we && e_rd == bus.rs1 && bus.rs1 != 0));
      chk("m_fwd2_hit", 32'(bus.fwd2_hit), 32'(e_we && e_rd == bus.rs2 && bus.rs2 != 0));
      if (known) begin
        chk("m_fwd1_data", 32'(bus.fwd1_data), 32'(e_data));
        chk("m_fwd2_data", 32'(bus.fwd2_data), 32'(e_data));
      end
`else
      chk("m_fwd_off", {bus.fwd1_hit, bus.fwd2_hit, bus.fwd1_data, bus.fwd2_data[13:0]}, 32'h0);
`endif
    end
  end
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    bus.mem_valid = 0; bus.mem_rd = 0; bus.mem_data = 0;
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.rs1 = 0; bus.rs2 = 0;
    cyc();
    bus.mem_valid = 1; bus.mem_rd = 2; bus.mem_data = 16'h1111;
    bus.alu_valid = 1; bus.alu_rd = 4; bus.alu_data = 16'h2222;
    repeat (5) begin
      @(negedge CLK);
      chk("rst_mem_ready", 32'(bus.mem_ready), 0);
      chk("rst_alu_ready", 32'(bus.alu_ready), 0);
      chk("rst_rf_we", 32'(bus.rf_we), 0);
      cyc();
    end
    reset = 1;
    @(negedge CLK);
    chk("rel_mem_ready", 32'(bus.mem_ready), 1);
    chk("rel_alu_ready", 32'(bus.alu_ready), 0);
    chk("rel_rf_we_idle", 32'(bus.rf_we), 0);
    cyc();
    bus.mem_valid = 0;
    @(negedge CLK);
    chk("rel_rf_we", 32'(bus.rf_we), 1);
    chk("rel_rf_rd", 32'(bus.rf_rd), 2);
    chk("rel_alu_ready", 32'(bus.alu_ready), 1);
    cyc();
    bus.alu_valid = 0;
    @(negedge CLK);
    chk("rel_alu_wdata", 32'(bus.rf_writedata), 32'h2222);
    cyc();
    @(negedge CLK);
    chk("idle_rf_we", 32'(bus.rf_we), 0);
    chk("idle_rf_rd_hold", 32'(bus.rf_rd), 4);
    bus.mem_valid = 1; bus.mem_rd = 5; bus.mem_data = 16'hBEEF;
    #1;
    chk("memonly_ready", 32'(bus.mem_ready), 1);
    cyc();
    bus.mem_valid = 0;
    @(negedge CLK);
    chk("memonly_we", 32'(bus.rf_we), 1);
    chk("memonly_rd", 32'(bus.rf_rd), 5);
    chk("memonly_data", 32'(bus.rf_writedata), 32'hBEEF);
    cyc();
    bus.alu_valid = 1; bus.alu_rd = 7; bus.alu_data = 16'h1234;
    bus.mem_valid = 1; bus.mem_rd = 1; bus.mem_data = 16'h0101;
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK);
      chk("cont_mem_ready", 32'(bus.mem_ready), 1);
      chk("cont_alu_wait", 32'(bus.alu_ready), 0);
      cyc();
      bus.mem_rd = 4'(k + 1);
      bus.mem_data = 16'(k + 1) * 16'h0101;
    end
    @(negedge CLK);
    chk("aged_alu_ready", 32'(bus.alu_ready), 1);
    chk("aged_mem_ready", 32'(bus.mem_ready), 0);
    cyc();
    bus.alu_valid = 0;
    @(negedge CLK);
    chk("aged_rf_rd", 32'(bus.rf_rd), 7);
    chk("aged_rf_data", 32'(bus.rf_writedata), 32'h1234);
    chk("resume_mem_ready", 32'(bus.mem_ready), 1);
    cyc();
    bus.mem_valid = 0;
    @(negedge CLK);
    chk("resume_rf_rd", 32'(bus.rf_rd), 4);
    cyc();
    bus.alu_valid = 1; bus.alu_rd = 0; bus.alu_data = 16'hFFFF;
    #1;
    chk("zero_alu_ready", 32'(bus.alu_ready), 1);
    cyc();
    bus.alu_valid = 0;
    @(negedge CLK);
    chk("zero_rf_we", 32'(bus.rf_we), 0);
    chk("zero_no_retry", 32'(bus.alu_ready), 0);
    cyc();
    bus.alu_valid = 1; bus.alu_rd = 3; bus.alu_data = 16'h00A5;
    cyc();
    bus.alu_valid = 0; bus.rs1 = 3; bus.rs2 = 0;
    @(negedge CLK);
    chk("fwd_rf_we", 32'(bus.rf_we), 1);
`ifdef RF_WB_BYPASS_EN
    chk("fwd1_hit", 32'(bus.fwd1_hit), 1);
    chk("fwd1_data", 32'(bus.fwd1_data), 32'h00A5);
    chk("fwd2_hit", 32'(bus.fwd2_hit), 0);
`else
    chk("fwd1_hit_off", 32'(bus.fwd1_hit), 0);
    chk("fwd1_data_off", 32'(bus.fwd1_data), 0);
    chk("fwd2_hit_off", 32'(bus.fwd2_hit), 0);
`endif
    cyc();
    bus.rs2 = 3;
    bus.mem_valid = 1; bus.mem_rd = 9; bus.mem_data = 16'h9999;
    bus.alu_valid = 1; bus.alu_rd = 6; bus.alu_data = 16'h0066;
    cyc();
    cyc();
    reset = 0;
    @(negedge CLK);
    chk("midrst_mem_ready", 32'(bus.mem_ready), 0);
    cyc();
    reset = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      if (k == 0) chk("midrst_rf_we", 32'(bus.rf_we), 0);
      chk("midrst_mem_first", 32'(bus.mem_ready), 1);
      chk("midrst_alu_wait", 32'(bus.alu_ready), 0);
      cyc();
    end
    @(negedge CLK);
    chk("midrst_alu_aged", 32'(bus.alu_ready), 1);
    cyc();
    bus.alu_valid = 0; bus.mem_valid = 0;
    cyc();
    cyc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
